alu_decode_stage: RTL and testbench
===================================

Name: alu_decode_stage

Overview:
- Decode/operand stage that drives the execute-stage ALU: takes a fetched RV32I instruction plus register-file read data, produces the 4-bit ALU operation code and the two ALU operands (rda, rdx).
- Holds them in a pipeline register with a valid/ready handshake, stall back-pressure and flush.
- Sits between fetch/register-file read and the ALU.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- OPW, 4, width of the ALU operation code.

Ports:
- clk  input  1  stage clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction/operands present.
- in_ready  output  1  stage can accept this cycle.
- instr  input  32  instruction word.
- pc  input  32  instruction address.
- rs1_data  input  32  register-file read of instr[19:15].
- rs2_data  input  32  register-file read of instr[24:20].
- flush  input  1  kill the held and incoming instruction.
- out_valid  output  1  registered outputs valid.
- out_ready  input  1  ALU stage accepts.
- alu_op  output  4  ALU operation code.
- rda  output  32  ALU operand A.
- rdx  output  32  ALU operand B.
- rd  output  5  destination register.
- rd_we  output  1  write-back enable.
- illegal  output  1  unsupported instruction.

Behaviour:
- ALU codes (fixed): ADD=0000, SUB=1000, SLL=0001, SRL=0010, SRA=1010, AND=0011, OR=0100, XOR=0101, SLT=0110, SLTU=0111.
- Reset (reset=0, async): out_valid=0, alu_op=0000, rda=0, rdx=0, rd=0, rd_we=0, illegal=0. Registers hold these values until the first clk edge with reset=1.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational; it does not depend on flush.
  - Capture happens on a clk edge when in_valid && in_ready && !flush. Outputs update one cycle after capture; latency is 1.
  - If out_valid && !out_ready, all outputs hold stable, and in_ready=0.
  - If out_ready=1 and nothing is captured, out_valid falls to 0 next cycle. Data outputs keep their last values.
- Flush: on a clk edge with flush=1, out_valid goes to 0 and no capture occurs, even if in_valid && in_ready. Flush has priority over everything except reset.
- Decode by opcode instr[6:0]:
  - OP 0110011, funct3 mapping: 000 gives ADD, or SUB when instr[30]=1. 001=SLL, 010=SLT, 011=SLTU, 100=XOR. 101 gives SRL, or SRA when instr[30]=1. 110=OR, 111=AND.
  - OP: rda=rs1_data. rdx=rs2_data, except shifts use rdx={27'b0, rs2_data[4:0]}. rd_we=1.
  - OP-IMM 0010011: same funct3 mapping, but SUB is never produced; instr[30] is ignored for funct3=000.
  - OP-IMM: rda=rs1_data, rdx=sign-extended instr[31:20]. Shifts use rdx={27'b0, instr[24:20]}. rd_we=1.
  - OP-IMM shifts with instr[31:25] other than 0000000 / 0100000 are illegal.
  - LUI 0110111: ADD, rda=0, rdx={instr[31:12],12'b0}, rd_we=1.
  - AUIPC 0010111: ADD, rda=pc, rdx={instr[31:12],12'b0}, rd_we=1.
  - LOAD 0000011: ADD, rda=rs1_data, rdx=I-imm, rd_we=1 (address generation).
  - STORE 0100011: ADD, rda=rs1_data, rdx=sign-extended {instr[31:25],instr[11:7]}, rd_we=0.
  - OP with instr[31:25] other than 0000000 / 0100000, or 0100000 with funct3 not in {000,101}: illegal.
  - Any other opcode: illegal.
- Illegal instructions: illegal=1, alu_op=ADD, rda=0, rdx=0, rd_we=0. out_valid still asserts so the exception propagates.
- rd=instr[11:7] for every captured instruction. If rd=0, rd_we is forced to 0.
- Shift operands: rdx[31:5]=0 for every shift, so the ALU never sees a shift amount ≥32.
- Outputs are driven only from registers; there is no combinational path from instr to outputs.

Test Plan:
- Reset=0 mid-stream with out_valid=1 → out_valid=0 and all outputs 0 immediately (asynchronously); after release, the first accepted instr appears 1 cycle later.
- instr=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 → next cycle alu_op=0000, rda=5, rdx=7, rd=3, rd_we=1. instr=0x402081B3 → alu_op=1000.
- instr=0x40335293 (srai x5,x6,3), rs1=0x80000000 → alu_op=1010, rdx=0x00000003. Register sll with rs2=0xFFFFFFE5 → rdx=0x00000005.
- instr=0x123450B7 (lui) → ADD, rda=0, rdx=0x12345000. instr=0xFFF00093 (addi x1,x0,-1) → rdx=0xFFFFFFFF. Store to rd field 0 → rd_we=0.
- Stall: out_valid=1, out_ready=0 for 3 cycles with new in_valid → in_ready=0 and outputs unchanged. out_ready=1 → the next instr is captured that edge.
- flush=1 with in_valid=1 and in_ready=1 → out_valid=0 next cycle, nothing captured. instr=0x00000000 → illegal=1, rd_we=0, out_valid=1.

Source files
------------

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32I decode/operand stage feeding the ALU through a valid/ready pipeline register
module alu_decode_stage #(
  parameter int XLEN = 32,
  parameter int OPW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] rda,
  output logic [XLEN-1:0] rdx,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  logic [6:0] opc, f7;
  logic [2:0] f3, base;
  logic shift, f7_ok, cap;
  logic [OPW-1:0] d_op;
  logic [XLEN-1:0] d_a, d_x, i_imm, s_imm, u_imm;
  logic d_we, d_ill;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign shift = f3 == 3'b001 || f3 == 3'b101;
  assign f7_ok = f7 == 7'b0000000 || f7 == 7'b0100000;
  assign i_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign s_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign u_imm = {instr[31:12], 12'b0};
  // low three bits of the ALU code; bit 3 selects SUB/SRA
  assign base = f3 == 3'b000 ? 3'b000 :
                f3 == 3'b001 ? 3'b001 :
                f3 == 3'b010 ? 3'b110 :
                f3 == 3'b011 ? 3'b111 :
                f3 == 3'b100 ? 3'b101 :
                f3 == 3'b101 ? 3'b010 :
                f3 == 3'b110 ? 3'b100 : 3'b011;
  always_comb begin
    d_op = '0;
    d_a = '0;
    d_x = '0;
    d_we = 1'b0;
    d_ill = 1'b0;
    case (opc)
      OPC_OP: begin
        if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          d_op = {instr[30], base};
          d_a = rs1_data;
          d_x = shift ? {{(XLEN-5){1'b0}}, rs2_data[4:0]} : rs2_data;
          d_we = 1'b1;
        end else d_ill = 1'b1;
      end
      OPC_IMM: begin
        if (!shift || f7_ok) begin
          d_op = {instr[30] && f3 == 3'b101, base};
          d_a = rs1_data;
          d_x = shift ? {{(XLEN-5){1'b0}}, instr[24:20]} : i_imm;
          d_we = 1'b1;
        end else d_ill = 1'b1;
      end
      OPC_LUI: begin
        d_x = u_imm;
        d_we = 1'b1;
      end
      OPC_AUIPC: begin
        d_a = pc;
        d_x = u_imm;
        d_we = 1'b1;
      end
      OPC_LOAD: begin
        d_a = rs1_data;
        d_x = i_imm;
        d_we = 1'b1;
      end
      OPC_STORE: begin
        d_a = rs1_data;
        d_x = s_imm;
      end
      default: d_ill = 1'b1;
    endcase
  end
  assign in_ready = !out_valid || out_ready;
  assign cap = in_valid && in_ready && !flush;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      alu_op <= '0;
      rda <= '0;
      rdx <= '0;
      rd <= '0;
      rd_we <= 1'b0;
      illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (cap) begin
      out_valid <= 1'b1;
      alu_op <= d_op;
      rda <= d_a;
      rdx <= d_x;
      rd <= instr[11:7];
      rd_we <= d_we && instr[11:7] != 5'd0;
      illegal <= d_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed-vector bench for the decode/operand stage
module tb_alu_decode_stage;
  logic clk = 1'b0, reset = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0;
  logic in_ready, out_valid, rd_we, illegal;
  logic [3:0] alu_op;
  logic [31:0] rda, rdx;
  logic [4:0] rd;
  logic [75:0] obs;
  int checks = 0, errors = 0;

  alu_decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .rda(rda), .rdx(rdx), .rd(rd), .rd_we(rd_we), .illegal(illegal)
  );

  always #5 clk = ~clk;
  assign obs = {out_valid, alu_op, rda, rdx, rd, rd_we, illegal};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    instr = i;
    rs1_data = a;
    rs2_data = b;
  endtask

  task automatic chk(input string name, input logic [75:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic test_reset;
    #12;
    chk("reset_outputs", 76'h0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    #2 reset = 1'b1;
  endtask

  task automatic test_op;
    out_ready = 1'b1;
    drive(32'h002081B3, 32'd5, 32'd7);
    step;
    chk("add", {1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0});
    drive(32'h402081B3, 32'd5, 32'd7);
    step;
    chk("sub", {1'b1, 4'b1000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0});
    drive(32'h0020C1B3, 32'hF0F0F0F0, 32'h0FF00FF0);
    step;
    chk("xor", {1'b1, 4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd3, 1'b1, 1'b0});
    drive(32'h402091B3, 32'd1, 32'd2);
    step;
    chk("illegal_op_f7", {1'b1, 4'b0000, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1});
  endtask

  task automatic test_shift;
    drive(32'h40335293, 32'h80000000, 32'hDEADBEEF);
    step;
    chk("srai", {1'b1, 4'b1010, 32'h80000000, 32'h00000003, 5'd5, 1'b1, 1'b0});
    drive(32'h002091B3, 32'd9, 32'hFFFFFFE5);
    step;
    chk("sll_reg", {1'b1, 4'b0001, 32'd9, 32'h00000005, 5'd3, 1'b1, 1'b0});
    drive(32'h02109093, 32'd9, 32'd0);
    step;
    chk("illegal_slli_f7", {1'b1, 4'b0000, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1});
  endtask

  task automatic test_imm;
    drive(32'h123450B7, 32'h55555555, 32'd0);
    step;
    chk("lui", {1'b1, 4'b0000, 32'd0, 32'h12345000, 5'd1, 1'b1, 1'b0});
    drive(32'hFFF00093, 32'd0, 32'd0);
    step;
    chk("addi_neg", {1'b1, 4'b0000, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0});
    pc = 32'h00000100;
    drive(32'h00001197, 32'd0, 32'd0);
    step;
    chk("auipc", {1'b1, 4'b0000, 32'h100, 32'h00001000, 5'd3, 1'b1, 1'b0});
    drive(32'h00812283, 32'h2000, 32'd0);
    step;
    chk("load", {1'b1, 4'b0000, 32'h2000, 32'd8, 5'd5, 1'b1, 1'b0});
    drive(32'h0020A023, 32'h3000, 32'd4);
    step;
    chk("store_rd0", {1'b1, 4'b0000, 32'h3000, 32'd0, 5'd0, 1'b0, 1'b0});
    drive(32'hFE20AE23, 32'h3000, 32'd4);
    step;
    chk("store_neg", {1'b1, 4'b0000, 32'h3000, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b0});
    drive(32'h00000013, 32'd0, 32'd0);
    step;
    chk("nop_rd0", {1'b1, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0});
  endtask

  task automatic test_stall;
    drive(32'h002081B3, 32'd1, 32'd2);
    step;
    chk("stall_first", {1'b1, 4'b0000, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0});
    out_ready = 1'b0;
    drive(32'h402081B3, 32'd10, 32'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready);
      end
      step;
      chk("stall_hold", {1'b1, 4'b0000, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready: got %b expected 1", in_ready);
    end
    step;
    chk("stall_release", {1'b1, 4'b1000, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0});
    in_valid = 1'b0;
    step;
    chk("drain", {1'b0, 4'b1000, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0});
  endtask

  task automatic test_flush;
    flush = 1'b1;
    drive(32'h002081B3, 32'd5, 32'd7);
    step;
    chk("flush_idle", {1'b0, 4'b1000, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0});
    flush = 1'b0;
    step;
    chk("refill", {1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0});
    out_ready = 1'b0;
    flush = 1'b1;
    step;
    chk("flush_held", {1'b0, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0});
    flush = 1'b0;
    out_ready = 1'b1;
    drive(32'h00000000, 32'd5, 32'd7);
    step;
    chk("illegal_zero", {1'b1, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1});
  endtask

  task automatic test_reset_mid;
    drive(32'h002081B3, 32'd5, 32'd7);
    step;
    #1 reset = 1'b0;
    #1;
    chk("async_reset", 76'h0);
    #1 reset = 1'b1;
    drive(32'h0020C1B3, 32'd6, 32'd3);
    step;
    chk("after_reset", {1'b1, 4'b0101, 32'd6, 32'd3, 5'd3, 1'b1, 1'b0});
  endtask

  initial begin
    test_reset;
    test_op;
    test_shift;
    test_imm;
    test_stall;
    test_flush;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
